// File: rtl/sys_bus_interconnect_if.sv
// sys_bus_interconnect_if: PS master bus plus the fanned-out peripheral slave bus.
// The slave modport is the interconnect's view; the master modport is the environment's view.
interface sys_bus_interconnect_if #(
    parameter int SN = 8,
    parameter int SW = 20,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic           m_wen;
    logic           m_ren;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_wdata;
    logic [DW-1:0]  m_rdata;
    logic           m_ack;
    logic           m_err;
    logic [SN-1:0]  s_wen;
    logic [SN-1:0]  s_ren;
    logic [SW-1:0]  s_addr;
    logic [DW-1:0]  s_wdata;
    logic [SN*DW-1:0] s_rdata;
    logic [SN-1:0]  s_ack;
    logic [SN-1:0]  s_err;
    modport slave (
        input  m_wen, m_ren, m_addr, m_wdata, s_rdata, s_ack, s_err,
        output m_rdata, m_ack, m_err, s_wen, s_ren, s_addr, s_wdata
    );
    modport master (
        output m_wen, m_ren, m_addr, m_wdata, s_rdata, s_ack, s_err,
        input  m_rdata, m_ack, m_err, s_wen, s_ren, s_addr, s_wdata
    );
endinterface

// File: rtl/sys_bus_interconnect.sv
// sys_bus_interconnect: single-outstanding system-bus demux from one master to SN slaves,
// with decode-error and timeout responses.
module sys_bus_interconnect #(
    parameter int SN = 8,
    parameter int SW = 20,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TO = 255
) (
    input logic clk,
    input logic rstn,
    sys_bus_interconnect_if.slave bus
);
    localparam int LN = $clog2(SN);
    localparam int CW = $clog2(TO + 1);
    typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;
    state_t         state_q, state_d;
    logic [LN-1:0]  sel_q, sel_d;
    logic           wr_q, wr_d, stb_q, stb_d, err_q, err_d;
    logic [SW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           req, dec_ok, hit_ack, hit_err;
    always_comb begin
        req     = bus.m_wen | bus.m_ren;
        dec_ok  = (bus.m_wen ^ bus.m_ren) && ((bus.m_addr >> (SW + LN)) == '0);
        hit_ack = bus.s_ack[sel_q];
        hit_err = bus.s_err[sel_q];
        state_d = state_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        stb_d   = 1'b0;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (dec_ok) begin
                    sel_d   = bus.m_addr[SW +: LN];
                    wr_d    = bus.m_wen;
                    addr_d  = bus.m_addr[SW-1:0];
                    wdata_d = bus.m_wdata;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = PEND;
                end else if (req) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            PEND: begin
                // a response wins over the timeout even on the final count
                if (hit_ack || hit_err) begin
                    err_d   = hit_err;
                    rdata_d = bus.s_rdata[sel_q*DW +: DW];
                    state_d = RESP;
                end else if (cnt_q == CW'(TO)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.s_wen   = (stb_q && wr_q)  ? ({{(SN-1){1'b0}}, 1'b1} << sel_q) : '0;
    assign bus.s_ren   = (stb_q && !wr_q) ? ({{(SN-1){1'b0}}, 1'b1} << sel_q) : '0;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;
    assign bus.m_rdata = rdata_q;
    assign bus.m_ack   = (state_q == RESP) && !err_q;
    assign bus.m_err   = (state_q == RESP) && err_q;
endmodule

// File: tb/tb_sys_bus_interconnect.sv
// tb_sys_bus_interconnect: directed vector table, hand-written corner sequences and
// randomized transactions checked against a latency-rule reference model.
module tb_sys_bus_interconnect;
    localparam int TO = 255;
    typedef struct {
        logic        wr, rd;
        logic [31:0] addr, wdata;
        int          rsp;
        logic        ack, err;
        logic [31:0] rdata;
        logic        noise;
        logic [7:0]  stb;
        int          done;
        logic        eerr;
        logic [31:0] erdata;
    } vec_t;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int applied = 0;
    int miscompares = 0;
    vec_t tbl[7];
    vec_t v;
    int op;
    always #5 clk = ~clk;
    sys_bus_interconnect_if #(.SN(8), .SW(20), .AW(32), .DW(32)) bus ();
    sys_bus_interconnect #(.SN(8), .SW(20), .AW(32), .DW(32), .TO(TO)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic vec_t mk(input logic wr, rd, input logic [31:0] addr, wdata, input int rsp,
                                input logic ack, err, input logic [31:0] rdata, input logic noise,
                                input logic [7:0] stb, input int done, input logic eerr,
                                input logic [31:0] erdata);
        vec_t r;
        r.wr = wr; r.rd = rd; r.addr = addr; r.wdata = wdata; r.rsp = rsp;
        r.ack = ack; r.err = err; r.rdata = rdata; r.noise = noise;
        r.stb = stb; r.done = done; r.eerr = eerr; r.erdata = erdata;
        return r;
    endfunction
    // Reference: derive outcome from the decode rule and the latency rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit ok = (v.wr != v.rd) && ((v.addr >> 23) == 0);
        r.stb = ok ? 8'(1 << v.addr[22:20]) : 8'h00;
        if (!ok) begin
            r.done = 1; r.eerr = 1'b1; r.erdata = 32'h0;
        end else if (v.rsp >= 1 && v.rsp <= TO + 1 && (v.ack || v.err)) begin
            r.done = v.rsp + 1; r.eerr = v.err; r.erdata = v.rdata;
        end else begin
            r.done = TO + 2; r.eerr = 1'b1; r.erdata = 32'h0;
        end
        return r;
    endfunction
    task automatic clear_slaves();
        bus.s_ack = '0;
        bus.s_err = '0;
        bus.s_rdata = '0;
    endtask
    task automatic apply(input vec_t v);
        int sel = int'(v.addr[22:20]);
        bus.m_wen = v.wr;
        bus.m_ren = v.rd;
        bus.m_addr = v.addr;
        bus.m_wdata = v.wdata;
        cyc();
        bus.m_wen = 1'b0;
        bus.m_ren = 1'b0;
        for (int c = 1; c <= v.done; c++) begin
            bus.s_ack = v.noise ? (8'($urandom) & ~v.stb) : 8'h00;
            bus.s_err = v.noise ? (8'($urandom) & ~v.stb) : 8'h00;
            bus.s_rdata = v.noise ? {8{$urandom}} : '0;
            if (c == v.rsp && v.stb != 0) begin
                bus.s_ack[sel] = v.ack;
                bus.s_err[sel] = v.err;
                bus.s_rdata[sel*32 +: 32] = v.rdata;
            end
            chk("strobe", {bus.s_wen, bus.s_ren},
                c == 1 ? (v.wr ? {v.stb, 8'h00} : {8'h00, v.stb}) : 16'h0);
            if (c == 1 && v.stb != 0) begin
                chk("s_addr", 64'(bus.s_addr), 64'(v.addr[19:0]));
                chk("s_wdata", 64'(bus.s_wdata), 64'(v.wdata));
            end
            chk("resp", {bus.m_ack, bus.m_err}, c == v.done ? (v.eerr ? 2'b01 : 2'b10) : 2'b00);
            if (c == v.done) chk("rdata", 64'(bus.m_rdata), 64'(v.erdata));
            cyc();
        end
        clear_slaves();
        chk("idle", {bus.m_ack, bus.m_err}, 2'b00);
        chk("hold", 64'(bus.m_rdata), 64'(v.erdata));
    endtask
    initial begin
        bus.m_wen = 1'b0; bus.m_ren = 1'b0; bus.m_addr = '0; bus.m_wdata = '0;
        clear_slaves();
        tbl[0] = mk(1, 0, 32'h0030_0010, 32'hA5A5_0001, 3, 1, 0, 32'hDEAD_0003, 0, 8'h08, 4, 0, 32'hDEAD_0003);
        tbl[1] = mk(0, 1, 32'h0050_0004, 32'h0, 2, 1, 0, 32'h1234_5678, 1, 8'h20, 3, 0, 32'h1234_5678);
        tbl[2] = mk(0, 1, 32'h0180_0000, 32'h0, 1, 1, 0, 32'h5555_5555, 0, 8'h00, 1, 1, 32'h0);
        tbl[3] = mk(1, 1, 32'h0010_0000, 32'h1, 1, 1, 0, 32'h6666_6666, 0, 8'h00, 1, 1, 32'h0);
        tbl[4] = mk(0, 1, 32'h0010_0008, 32'h0, 2, 1, 1, 32'hCAFE_F00D, 1, 8'h02, 3, 1, 32'hCAFE_F00D);
        tbl[5] = mk(0, 1, 32'h0070_0000, 32'h0, 1, 1, 0, 32'h0000_0077, 0, 8'h80, 2, 0, 32'h0000_0077);
        tbl[6] = mk(1, 0, 32'h000F_FFFC, 32'h1357_9BDF, 4, 0, 1, 32'h0BAD_0000, 1, 8'h01, 5, 1, 32'h0BAD_0000);
        repeat (3) cyc();
        chk("rst_m", {bus.m_ack, bus.m_err, bus.m_rdata}, 0);
        chk("rst_s", {bus.s_wen, bus.s_ren, bus.s_addr}, 0);
        chk("rst_wd", 64'(bus.s_wdata), 0);
        rstn = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) apply(tbl[i]);
        // timeout, then a late ack at cycle TO+5 must be ignored
        apply(mk(0, 1, 32'h0020_0000, 32'h0, 0, 0, 0, 32'h0, 0, 8'h04, TO + 2, 1, 32'h0));
        cyc();
        bus.s_ack[2] = 1'b1;
        bus.s_rdata[2*32 +: 32] = 32'hFFFF_0002;
        cyc();
        clear_slaves();
        repeat (3) begin
            chk("late_ack", {bus.m_ack, bus.m_err, bus.s_wen, bus.s_ren}, 0);
            cyc();
        end
        apply(mk(0, 1, 32'h0020_0040, 32'h0, 2, 1, 0, 32'h2222_0002, 0, 8'h04, 3, 0, 32'h2222_0002));
        // master strobe while PEND is dropped; ack+err together gives m_err only
        bus.m_ren = 1'b1; bus.m_addr = 32'h0010_0000;
        cyc();
        bus.m_ren = 1'b0;
        chk("pend_ren", {bus.s_wen, bus.s_ren}, 16'h0002);
        cyc();
        bus.m_wen = 1'b1; bus.m_addr = 32'h0040_0000; bus.m_wdata = 32'h4444_4444;
        cyc();
        bus.m_wen = 1'b0;
        chk("pend_drop", {bus.s_wen, bus.s_ren, bus.m_ack, bus.m_err}, 0);
        bus.s_ack[1] = 1'b1; bus.s_err[1] = 1'b1; bus.s_rdata[1*32 +: 32] = 32'hBEEF_0001;
        cyc();
        clear_slaves();
        chk("both_resp", {bus.m_ack, bus.m_err}, 2'b01);
        chk("both_rdata", 64'(bus.m_rdata), 64'h0000_0000_BEEF_0001);
        repeat (3) begin
            cyc();
            chk("no_extra", {bus.m_ack, bus.m_err, bus.s_wen, bus.s_ren}, 0);
        end
        // reset while PEND aborts without response and ignores the old ack
        cyc();
        bus.m_ren = 1'b1; bus.m_addr = 32'h0060_0000;
        cyc();
        bus.m_ren = 1'b0;
        chk("pre_rst", {bus.s_wen, bus.s_ren}, 16'h0040);
        cyc();
        rstn = 1'b0;
        #1;
        chk("arst_m", {bus.m_ack, bus.m_err, bus.m_rdata}, 0);
        chk("arst_s", {bus.s_wen, bus.s_ren, bus.s_addr}, 0);
        chk("arst_wd", 64'(bus.s_wdata), 0);
        cyc();
        rstn = 1'b1;
        bus.s_ack[6] = 1'b1;
        cyc();
        clear_slaves();
        repeat (3) begin
            chk("post_rst", {bus.m_ack, bus.m_err, bus.s_wen, bus.s_ren}, 0);
            cyc();
        end
        apply(mk(1, 0, 32'h0000_0100, 32'h0F0F_0F0F, 2, 1, 0, 32'h0000_00AA, 0, 8'h01, 3, 0, 32'h0000_00AA));
        // randomized transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 9);
            v.wr = (op < 5) || (op == 9);
            v.rd = (op >= 5);
            v.addr = $urandom & 32'h007F_FFFF;
            if ($urandom_range(0, 7) == 0) v.addr[31:23] = 9'($urandom_range(1, 511));
            v.wdata = $urandom;
            v.rsp = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
            v.ack = 1'($urandom);
            v.err = 1'($urandom);
            if (!v.ack && !v.err) v.ack = 1'b1;
            v.rdata = $urandom;
            v.noise = 1'($urandom);
            apply(model(v));
            repeat ($urandom_range(0, 2)) cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
